// File: rtl/rmii_pkg.sv
// rmii_pkg: shared types and constants for the RMII receive aggregator.
//   port_state_e   - per-port receive FSM state
//   PREAMBLE_DIBIT - dibit repeated throughout the preamble
//   SFD_DIBIT      - final dibit of the start-of-frame delimiter
//   DIV10          - cycles per dibit at 10 Mb/s
//   SAMPLE_IDX     - 10 Mb/s counter value at which a dibit is sampled
package rmii_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA} port_state_e;
    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT = 2'b11;
    localparam int unsigned DIV10 = 10;
    localparam int unsigned SAMPLE_IDX = 4;
endpackage

// File: rtl/rmii_rx_port.sv
// rmii_rx_port: one RMII receive port - sampler, frame FSM and byte assembler.
//   clk_i, resetn_i   - clock, asynchronous active-low reset
//   speed_10_i        - 1 = 10 Mb/s (dibit held 10 cycles), 0 = 100 Mb/s
//   crs_dv_i, rx_d_i, rx_er_i - RMII receive inputs
//   sfd_o    - this sample point moves the port into DATA
//   byte_v_o - this sample point completes a byte, presented on byte_o
//   end_o    - this sample point ends the frame
//   err_o    - sticky frame error including the current sample
module rmii_rx_port
    import rmii_pkg::*;
(
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       speed_10_i,
    input  logic       crs_dv_i,
    input  logic [1:0] rx_d_i,
    input  logic       rx_er_i,
    output logic       sfd_o,
    output logic       byte_v_o,
    output logic [7:0] byte_o,
    output logic       end_o,
    output logic       err_o
);
    port_state_e state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  idx_q;
    logic [7:0]  sh_q;
    logic        err_q;
    logic        sample, in_data, cnt_hold;

    // At 10 Mb/s the counter is parked at 0 until carrier appears, so the
    // first dibit of a frame is sampled 4 cycles in, mid-way through its hold.
    assign cnt_hold = !speed_10_i || (state_q == ST_IDLE && !crs_dv_i);
    assign sample   = !speed_10_i || cnt_q == 4'(SAMPLE_IDX);
    assign in_data  = sample && state_q == ST_DATA;
    assign sfd_o    = sample && state_q == ST_PREAMBLE && crs_dv_i && rx_d_i == SFD_DIBIT;
    assign byte_v_o = in_data && idx_q == 2'd3;
    assign byte_o   = {rx_d_i, sh_q[7:2]};
    // crs_dv low mid-byte is a carrier toggle; only a byte boundary ends the frame
    assign end_o    = in_data && idx_q == 2'd0 && !crs_dv_i;
    assign err_o    = err_q || (in_data && rx_er_i);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= (cnt_hold || cnt_q == 4'(DIV10 - 1)) ? 4'd0 : cnt_q + 4'd1;
            if (sample) begin
                case (state_q)
                    ST_IDLE: if (crs_dv_i && rx_d_i == PREAMBLE_DIBIT) state_q <= ST_PREAMBLE;
                    ST_PREAMBLE: begin
                        if (sfd_o) begin
                            state_q <= ST_DATA;
                            idx_q   <= '0;
                            err_q   <= 1'b0;
                        end else if (!crs_dv_i || rx_d_i != PREAMBLE_DIBIT) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        if (end_o) begin
                            state_q <= ST_IDLE;
                        end else begin
                            sh_q  <= byte_o;
                            idx_q <= idx_q + 2'd1;
                            err_q <= err_o;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/rmii_rx_aggregator.sv
// rmii_rx_aggregator: merges N_PORTS RMII receivers onto one byte stream.
//   clk_50_mhz, resetn - RMII reference clock, asynchronous active-low reset
//   speed_10           - 1 = 10 Mb/s, 0 = 100 Mb/s (change only when idle)
//   crs_dv, rx_d, rx_er - per-port RMII inputs, port p on rx_d[2p+1:2p]
//   m_data/m_valid/m_sof - received byte, one-cycle valid, first-byte flag
//   m_eof/m_err        - end-of-frame pulse and its error flag
//   m_port             - source port of the current frame
//   drop_cnt           - saturating count of frames refused by the lock
module rmii_rx_aggregator
    import rmii_pkg::*;
#(
    parameter  int N_PORTS = 2,
    parameter  int CNT_W   = 16,
    localparam int PW      = N_PORTS > 1 ? $clog2(N_PORTS) : 1
) (
    input  logic                 clk_50_mhz,
    input  logic                 resetn,
    input  logic                 speed_10,
    input  logic [N_PORTS-1:0]   crs_dv,
    input  logic [2*N_PORTS-1:0] rx_d,
    input  logic [N_PORTS-1:0]   rx_er,
    output logic [7:0]           m_data,
    output logic                 m_valid,
    output logic                 m_sof,
    output logic                 m_eof,
    output logic                 m_err,
    output logic [PW-1:0]        m_port,
    output logic [CNT_W-1:0]     drop_cnt
);
    logic [N_PORTS-1:0] sfd, byte_v, end_v, err_v;
    logic [7:0]         bytes [N_PORTS];
    logic               lock_q, first_q, any, grant, out_byte, out_end;
    logic [PW-1:0]      gnt_q, rr_q, win, k;
    logic [7:0]         m_data_q;
    logic               m_valid_q, m_sof_q, m_eof_q, m_err_q;
    logic [PW-1:0]      m_port_q;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W+3:0]   drop_sum;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        rmii_rx_port u_port (
            .clk_i     (clk_50_mhz),
            .resetn_i  (resetn),
            .speed_10_i(speed_10),
            .crs_dv_i  (crs_dv[p]),
            .rx_d_i    (rx_d[2*p+:2]),
            .rx_er_i   (rx_er[p]),
            .sfd_o     (sfd[p]),
            .byte_v_o  (byte_v[p]),
            .byte_o    (bytes[p]),
            .end_o     (end_v[p]),
            .err_o     (err_v[p])
        );
    end

    // Scan backwards from the pointer so the last hit is the nearest
    // requester at or after rr_q.
    always_comb begin
        any = 1'b0;
        win = '0;
        k   = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            k = PW'((int'(rr_q) + i) % N_PORTS);
            if (sfd[k]) begin
                any = 1'b1;
                win = k;
            end
        end
    end

    // lock_q is still set in the granted port's end cycle, so a port
    // entering DATA in that same cycle is refused.
    assign grant    = any && !lock_q;
    assign out_byte = lock_q && byte_v[gnt_q];
    assign out_end  = lock_q && end_v[gnt_q];
    assign drop_sum = (CNT_W+4)'(drop_q) + (CNT_W+4)'($countones(sfd)) - (CNT_W+4)'(grant);
    assign drop_d   = drop_sum > (CNT_W+4)'({CNT_W{1'b1}}) ? '1 : drop_sum[CNT_W-1:0];

    always_ff @(posedge clk_50_mhz or negedge resetn) begin
        if (!resetn) begin
            lock_q    <= 1'b0;
            first_q   <= 1'b0;
            gnt_q     <= '0;
            rr_q      <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eof_q   <= 1'b0;
            m_err_q   <= 1'b0;
            m_port_q  <= '0;
            drop_q    <= '0;
        end else begin
            m_valid_q <= out_byte;
            m_sof_q   <= out_byte && first_q;
            m_eof_q   <= out_end;
            m_err_q   <= out_end && err_v[gnt_q];
            drop_q    <= drop_d;
            if (out_byte) begin
                m_data_q <= bytes[gnt_q];
                first_q  <= 1'b0;
            end
            if (out_end) lock_q <= 1'b0;
            if (grant) begin
                lock_q   <= 1'b1;
                first_q  <= 1'b1;
                gnt_q    <= win;
                m_port_q <= win;
                rr_q     <= (int'(win) == N_PORTS - 1) ? '0 : win + PW'(1);
            end
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_sof    = m_sof_q;
    assign m_eof    = m_eof_q;
    assign m_err    = m_err_q;
    assign m_port   = m_port_q;
    assign drop_cnt = drop_q;
endmodule

// File: doc/rmii_rx_aggregator.md
RMII_RX_AGGREGATOR -- requirements
Module: rmii_rx_aggregator

Interface
REQ-001 Parameter N_PORTS, default 2: number of RMII receive ports, range 1..8.
REQ-002 Parameter CNT_W, default 16: width of the dropped-frame counter.
REQ-003 Port list: clock and reset first.
- clk_50_mhz  in  1  RMII reference clock.
- resetn  in  1  reset.
REQ-004 One clock; resetn is asynchronous and active-low.
REQ-005 Remaining ports:
- speed_10  in  1  1 = 10 Mb/s (each dibit held 10 cycles), 0 = 100 Mb/s.
- crs_dv  in  N_PORTS  per-port carrier sense / data valid.
- rx_d  in  2*N_PORTS  per-port dibit; port p occupies bits [2p+1:2p].
- rx_er  in  N_PORTS  per-port receive error.
- m_data  out  8  received byte.
- m_valid  out  1  m_data valid, single-cycle.
- m_sof  out  1  first byte of frame, qualified by m_valid.
- m_eof  out  1  end-of-frame pulse, always with m_valid=0.
- m_err  out  1  frame error, qualified by m_eof.
- m_port  out  max(1,$clog2(N_PORTS))  source port of the current frame.
- drop_cnt  out  CNT_W  frames dropped because the output was locked.

Function
REQ-006 Sample point: every cycle when speed_10=0. When speed_10=1, a per-port 0..9 counter held at 0 while the port is IDLE with crs_dv=0; sampling occurs when the counter equals 4.
REQ-007 speed_10 SHALL change only while all ports are IDLE; behaviour otherwise is unspecified.
REQ-008 Per-port FSM states: IDLE, PREAMBLE, DATA. All transitions occur on sample points only.
REQ-009 IDLE -> PREAMBLE when crs_dv=1 and dibit=01.
REQ-010 PREAMBLE transitions:
- stays on 01.
- -> DATA on 11 (SFD), with the dibit index cleared.
- -> IDLE on crs_dv=0, 00 or 10.
REQ-011 DATA, byte assembly: dibits arrive LSB-first; shift byte = {dibit, byte[7:2]}. After the 4th dibit the byte is presented.
REQ-012 DATA, crs_dv handling: crs_dv=0 at dibit index 0 ends the frame and returns the port to IDLE. crs_dv=0 at index 1..3 is a carrier toggle; that dibit is accepted.
REQ-013 rx_er=1 on any DATA sample point sets a per-port sticky error. The error clears on entry to DATA.
REQ-014 Output lock: a port entering DATA while the output is free is granted. Only the granted port drives m_*.
REQ-015 Simultaneous entries into DATA: grant round-robin, starting at the port after the last granted one. The pointer resets so that port 0 has first priority.
REQ-016 A port entering DATA while the output is locked, or losing arbitration, has its frame discarded. drop_cnt increments once per discarded frame and saturates at all-ones.
REQ-017 Byte latency: m_valid, m_data and m_port are registered and asserted the cycle after the 4th dibit's sample point. m_sof=1 on the first byte only.
REQ-018 m_eof pulses the cycle after the granted port's end condition, with m_err equal to its sticky error. The lock is released in the m_eof cycle.
REQ-019 A port ending a frame in the same cycle another port enters DATA: the entering port SHALL see the output as locked.
REQ-020 No backpressure: maximum output rate is one byte per 4 cycles.

Reset
REQ-021 Asserting resetn SHALL immediately do all of the following:
- force every output to 0;
- force all FSMs to IDLE;
- clear the dibit counters, 10 Mb/s counters, sticky errors, the lock and drop_cnt;
- point round-robin at port 0.
REQ-022 A frame interrupted by reset SHALL produce no m_eof. Frames starting after resetn deasserts are received normally.

Structure
REQ-023 Package rmii_pkg SHALL hold:
- the port-FSM state enum;
- dibit constants PREAMBLE_DIBIT=2'b01 and SFD_DIBIT=2'b11;
- the 10 Mb/s divide constant 10 and its sample index 4.
REQ-024 Sub-module rmii_rx_port: per-port sampler, FSM and byte assembler, instantiated N_PORTS times. Arbitration, the output mux and drop_cnt reside in rmii_rx_aggregator.

Verification
REQ-025 Port 0 at 100M, 7x0x55 + 0xD5 + 0x12, 0x34, then crs_dv=0 -> m_valid/m_sof with 0x12, 0x34 four cycles later, m_eof, m_err=0, m_port=0.
REQ-026 Same frame with rx_er=1 on one dibit of 0x34 -> bytes unchanged, m_err=1 at m_eof.
REQ-027 Ports 0 and 1 both hit SFD in the same cycle after reset -> port 0 frame output, drop_cnt=1. Repeat -> port 1 frame output, drop_cnt=2.
REQ-028 speed_10=1, each dibit held 10 cycles -> same bytes spaced 40 cycles apart.
REQ-029 resetn low after the first byte -> all outputs 0 at once, no m_eof. The next frame is received correctly.
REQ-030 CNT_W=2, five dropped frames -> drop_cnt=3 (saturated).
